// File: rtl/tx_pipe_arbiter.sv
// Two-source, packet-granular round-robin arbiter for the MAC TX FIFO write pipe.
// The grant is held until tlast; frames longer than MAX_BEATS are truncated and the rest drained.
module tx_pipe_arbiter #(
    parameter int MAC_WIDTH   = 8,
    parameter int TKEEP_WIDTH = 1,
    parameter int NIC_WIDTH   = MAC_WIDTH + TKEEP_WIDTH + 1,
    parameter int MAX_BEATS   = 1518,
    parameter int CNT_WIDTH   = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NIC_WIDTH-1:0] src0_data,
    input  logic                 src0_req,
    output logic                 src0_ack,
    input  logic [NIC_WIDTH-1:0] src1_data,
    input  logic                 src1_req,
    output logic                 src1_ack,
    output logic [NIC_WIDTH-1:0] out_data,
    output logic                 out_req,
    input  logic                 out_ack,
    output logic                 busy,
    output logic                 owner,
    output logic                 oversize_err,
    input  logic                 err_clear,
    output logic [15:0]          pkt_count0,
    output logic [15:0]          pkt_count1
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_BEATS - 1);

    if (NIC_WIDTH != MAC_WIDTH + TKEEP_WIDTH + 1) begin : g_bad_width
        $error("NIC_WIDTH must equal MAC_WIDTH+TKEEP_WIDTH+1");
    end
    if (MAX_BEATS < 2 || (64'd1 << CNT_WIDTH) <= 64'(MAX_BEATS)) begin : g_bad_cnt
        $error("MAX_BEATS must be >= 2 and fit in CNT_WIDTH bits");
    end

    logic [1:0]           r_state;
    logic                 r_prio;
    logic                 r_owner;
    logic                 r_err;
    logic [CNT_WIDTH-1:0] r_beat_cnt;
    logic [15:0]          r_pkt0;
    logic [15:0]          r_pkt1;

    logic [NIC_WIDTH-1:0] w_own_data;
    logic                 w_own_req;
    logic                 w_own_last;
    logic                 w_at_max;
    logic                 w_in_busy;
    logic                 w_in_drain;
    logic                 w_own_ack;
    logic                 w_fire;
    logic                 w_end_frame;
    logic                 w_trunc;
    logic                 w_drain_done;
    logic                 w_winner;

    assign w_own_data   = r_owner ? src1_data : src0_data;
    assign w_own_req    = r_owner ? src1_req  : src0_req;
    assign w_own_last   = w_own_data[NIC_WIDTH-1];
    assign w_at_max     = (r_beat_cnt == LAST_CNT);
    // Outputs are held quiet while reset is asserted, not just after it.
    assign w_in_busy    = (r_state == ST_BUSY)  && !reset;
    assign w_in_drain   = (r_state == ST_DRAIN) && !reset;
    assign w_fire       = w_in_busy && w_own_req && out_ack;
    assign w_end_frame  = w_fire && (w_own_last || w_at_max);
    assign w_trunc      = w_fire && w_at_max && !w_own_last;
    assign w_drain_done = w_in_drain && w_own_req && w_own_last;
    assign w_winner     = (src0_req && src1_req) ? r_prio : src1_req;
    assign w_own_ack    = (w_in_busy && out_ack && w_own_req) || (w_in_drain && w_own_req);

    assign src0_ack     = w_own_ack && !r_owner;
    assign src1_ack     = w_own_ack &&  r_owner;
    assign out_req      = w_in_busy && w_own_req;
    assign busy         = (r_state != ST_IDLE) && !reset;
    assign owner        = r_owner && !reset;
    assign oversize_err = r_err && !reset;
    assign pkt_count0   = reset ? 16'd0 : r_pkt0;
    assign pkt_count1   = reset ? 16'd0 : r_pkt1;

    // The last permitted beat carries a forced tlast so the FIFO sees a closed frame.
    always_comb begin
        out_data = '0;
        if (w_in_busy) begin
            out_data = w_own_data;
            if (w_at_max) out_data[NIC_WIDTH-1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_prio     <= 1'b0;
            r_owner    <= 1'b0;
            r_err      <= 1'b0;
            r_beat_cnt <= '0;
            r_pkt0     <= 16'd0;
            r_pkt1     <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (src0_req || src1_req) begin
                        r_owner    <= w_winner;
                        r_beat_cnt <= '0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_end_frame) begin
                        r_prio  <= ~r_owner;
                        r_state <= w_trunc ? ST_DRAIN : ST_IDLE;
                    end else if (w_fire) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_done) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_trunc)        r_err <= 1'b1;
            else if (err_clear) r_err <= 1'b0;

            if (w_end_frame && !r_owner) r_pkt0 <= r_pkt0 + 16'd1;
            if (w_end_frame &&  r_owner) r_pkt1 <= r_pkt1 + 16'd1;
        end
    end

endmodule

// File: tb/tb_tx_pipe_arbiter.sv
// Bench for tx_pipe_arbiter: directed scenarios plus randomized traffic, checked each cycle
// against a frame-level model and a per-source queue of expected output beats.
module tb_tx_pipe_arbiter;

    localparam int MW   = 8;
    localparam int KW   = 1;
    localparam int NW   = MW + KW + 1;
    localparam int MAXB = 4;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          reset, err_clear, out_ack;
    logic [NW-1:0] src0_data, src1_data, out_data;
    logic          src0_req, src1_req, src0_ack, src1_ack, out_req;
    logic          busy, owner, oversize_err;
    logic [15:0]   pkt_count0, pkt_count1;

    always #5 clk = ~clk;

    tx_pipe_arbiter #(
        .MAC_WIDTH(MW), .TKEEP_WIDTH(KW), .NIC_WIDTH(NW), .MAX_BEATS(MAXB), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .src0_data(src0_data), .src0_req(src0_req), .src0_ack(src0_ack),
        .src1_data(src1_data), .src1_req(src1_req), .src1_ack(src1_ack),
        .out_data(out_data), .out_req(out_req), .out_ack(out_ack),
        .busy(busy), .owner(owner), .oversize_err(oversize_err), .err_clear(err_clear),
        .pkt_count0(pkt_count0), .pkt_count1(pkt_count1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Words each source still has to offer, and the beats each must put on the TX pipe.
    logic [NW-1:0] src_q[2][$];
    logic [NW-1:0] exp_q[2][$];

    int   gap_pct  = 0;
    int   ack_mode = 0;
    bit   rand_err = 1'b0;
    logic ack_t    = 1'b0;

    // Frame-level model: 0 = no grant, 1 = passing a frame, 2 = discarding a frame tail.
    int          m_st    = 0;
    bit          m_prio  = 1'b0;
    bit          m_owner = 1'b0;
    bit          m_err   = 1'b0;
    int          m_beats = 0;
    logic [15:0] m_pkt[2] = '{16'd0, 16'd0};

    int acc_cyc[$];
    int grant_log[$];
    int disc_cnt = 0;
    int ack1_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic push_frame(input int s, input int len);
        logic [NW-1:0] w;
        for (int i = 0; i < len; i++) begin
            w = {1'(i == len - 1), MW'($urandom), {KW{1'b1}}};
            src_q[s].push_back(w);
            if (i < MAXB) begin
                if (i == MAXB - 1) w[NW-1] = 1'b1;
                exp_q[s].push_back(w);
            end
        end
    endtask

    task automatic drive();
        logic          r;
        logic [NW-1:0] d;
        for (int s = 0; s < 2; s++) begin
            r = 1'b0;
            d = NW'($urandom);
            if (src_q[s].size() != 0 && $urandom_range(99) >= 32'(gap_pct)) begin
                r = 1'b1;
                d = src_q[s][0];
            end
            if (s == 0) begin src0_req = r; src0_data = d; end
            else        begin src1_req = r; src1_data = d; end
        end
        case (ack_mode)
            0:       out_ack = 1'b1;
            1:       begin ack_t = ~ack_t; out_ack = ack_t; end
            default: out_ack = 1'($urandom_range(1));
        endcase
        if (rand_err) err_clear = ($urandom_range(7) == 0);
    endtask

    task automatic model();
        logic [NW-1:0] sd[2];
        logic          sr[2];
        logic [NW-1:0] e_data, want;
        logic          e_req, e_ack, last;
        bit            trunc;
        int            o;
        sd[0] = src0_data; sd[1] = src1_data;
        sr[0] = src0_req;  sr[1] = src1_req;
        o      = int'(m_owner);
        e_req  = 1'b0;
        e_ack  = 1'b0;
        e_data = '0;
        trunc  = 1'b0;
        if (!reset && m_st == 1) begin
            e_req  = sr[o];
            e_ack  = sr[o] && out_ack;
            e_data = sd[o];
            if (m_beats == MAXB - 1) e_data[NW-1] = 1'b1;
        end else if (!reset && m_st == 2) begin
            e_ack = sr[o];
        end

        chk("out_req",      32'(out_req),      32'(e_req));
        chk("src0_ack",     32'(src0_ack),     32'(e_ack && o == 0));
        chk("src1_ack",     32'(src1_ack),     32'(e_ack && o == 1));
        chk("busy",         32'(busy),         32'(!reset && m_st != 0));
        chk("owner",        32'(owner),        32'(!reset && m_owner));
        chk("oversize_err", 32'(oversize_err), 32'(!reset && m_err));
        chk("pkt_count0",   32'(pkt_count0),   reset ? 32'd0 : 32'(m_pkt[0]));
        chk("pkt_count1",   32'(pkt_count1),   reset ? 32'd0 : 32'(m_pkt[1]));
        if (e_req || reset) chk("out_data", 32'(out_data), 32'(e_data));

        if (reset) begin
            m_st = 0; m_prio = 1'b0; m_owner = 1'b0; m_err = 1'b0; m_beats = 0;
            m_pkt[0] = 16'd0; m_pkt[1] = 16'd0;
            return;
        end
        if (e_ack) begin
            if (src_q[o].size() != 0) void'(src_q[o].pop_front());
            if (o == 1) ack1_cnt++;
        end
        case (m_st)
            0: if (sr[0] || sr[1]) begin
                m_owner = (sr[0] && sr[1]) ? m_prio : sr[1];
                m_beats = 0;
                m_st    = 1;
                grant_log.push_back(int'(m_owner));
            end
            1: if (e_req && out_ack) begin
                acc_cyc.push_back(cyc);
                if (exp_q[o].size() == 0) flag_fail("unexpected beat on out");
                else begin
                    want = exp_q[o].pop_front();
                    chk("out_beat", 32'(out_data), 32'(want));
                end
                last = sd[o][NW-1];
                if (last || m_beats == MAXB - 1) begin
                    m_pkt[o] = m_pkt[o] + 16'd1;
                    m_prio   = !m_owner;
                    m_st     = last ? 0 : 2;
                    trunc    = !last;
                end else begin
                    m_beats++;
                end
            end
            default: if (sr[o]) begin
                disc_cnt++;
                if (sd[o][NW-1]) m_st = 0;
            end
        endcase
        if (trunc)          m_err = 1'b1;
        else if (err_clear) m_err = 1'b0;
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        model();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while ((src_q[0].size() != 0 || src_q[1].size() != 0 || m_st != 0) && n < budget) begin
            cycle();
            n++;
        end
        if (src_q[0].size() != 0 || src_q[1].size() != 0 || m_st != 0) flag_fail("timeout waiting for idle");
    endtask

    task automatic flush();
        for (int s = 0; s < 2; s++) begin
            src_q[s].delete();
            exp_q[s].delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush();
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, a0, g0, d0, k0;
        reset = 1'b1; err_clear = 1'b0; out_ack = 1'b0;
        src0_req = 1'b0; src1_req = 1'b0; src0_data = '0; src1_data = '0;
        @(posedge clk); #1;

        // Reset state
        do_reset();
        chk("rst_busy",    32'(busy),         32'd0);
        chk("rst_out_req", 32'(out_req),      32'd0);
        chk("rst_owner",   32'(owner),        32'd0);
        chk("rst_err",     32'(oversize_err), 32'd0);
        chk("rst_pkt0",    32'(pkt_count0),   32'd0);
        chk("rst_pkt1",    32'(pkt_count1),   32'd0);

        // Single source, 3 beats, out_ack held high
        c0 = cyc; a0 = acc_cyc.size(); k0 = ack1_cnt;
        push_frame(0, 3);
        run_idle(50);
        chk("t1_beats", 32'(acc_cyc.size() - a0), 32'd3);
        if (acc_cyc.size() - a0 == 3) begin
            chk("t1_latency", 32'(acc_cyc[a0] - c0),             32'd1);
            chk("t1_beat2",   32'(acc_cyc[a0+1] - acc_cyc[a0]),  32'd1);
            chk("t1_beat3",   32'(acc_cyc[a0+2] - acc_cyc[a0]),  32'd2);
        end
        chk("t1_pkt0",   32'(pkt_count0),     32'd1);
        chk("t1_src1ak", 32'(ack1_cnt - k0),  32'd0);
        chk("t1_bubble", 32'(busy),           32'd0);

        // Contention: two 2-beat frames per source, grants must alternate from src0
        do_reset();
        c0 = cyc; a0 = acc_cyc.size(); g0 = grant_log.size();
        push_frame(0, 2); push_frame(1, 2); push_frame(0, 2); push_frame(1, 2);
        run_idle(100);
        chk("t2_grants", 32'(grant_log.size() - g0), 32'd4);
        if (grant_log.size() - g0 == 4) begin
            chk("t2_g0", 32'(grant_log[g0]),   32'd0);
            chk("t2_g1", 32'(grant_log[g0+1]), 32'd1);
            chk("t2_g2", 32'(grant_log[g0+2]), 32'd0);
            chk("t2_g3", 32'(grant_log[g0+3]), 32'd1);
        end
        chk("t2_beats", 32'(acc_cyc.size() - a0), 32'd8);
        if (acc_cyc.size() - a0 == 8) chk("t2_span", 32'(acc_cyc[a0+7] - c0), 32'd11);
        chk("t2_pkt0", 32'(pkt_count0), 32'd2);
        chk("t2_pkt1", 32'(pkt_count1), 32'd2);

        // Backpressure: out_ack 0 on the arbitration cycle, then 1,0,1,0,...
        do_reset();
        ack_mode = 1; ack_t = 1'b1;
        c0 = cyc; a0 = acc_cyc.size();
        push_frame(0, 4);
        run_idle(50);
        ack_mode = 0;
        chk("t3_beats", 32'(acc_cyc.size() - a0), 32'd4);
        if (acc_cyc.size() - a0 == 4) chk("t3_cycles", 32'(acc_cyc[a0+3] - c0 + 1), 32'd8);
        chk("t3_left", 32'(exp_q[0].size()), 32'd0);
        chk("t3_pkt0", 32'(pkt_count0),      32'd1);

        // Oversize: 6-beat frame on src1 against MAX_BEATS=4
        do_reset();
        a0 = acc_cyc.size(); d0 = disc_cnt; k0 = ack1_cnt;
        push_frame(1, 6);
        run_idle(50);
        chk("t4_beats",   32'(acc_cyc.size() - a0), 32'd4);
        chk("t4_discard", 32'(disc_cnt - d0),       32'd2);
        chk("t4_acks",    32'(ack1_cnt - k0),       32'd6);
        chk("t4_err",     32'(oversize_err),        32'd1);
        chk("t4_pkt1",    32'(pkt_count1),          32'd1);
        err_clear = 1'b1;
        cycle();
        err_clear = 1'b0;
        chk("t4_err_clr", 32'(oversize_err), 32'd0);

        // Reset mid-frame; prio is first moved to src1 so the post-reset win proves it was cleared
        do_reset();
        push_frame(0, 1);
        run_idle(20);
        a0 = acc_cyc.size();
        push_frame(0, 5);
        for (int n = 0; n < 20 && acc_cyc.size() - a0 < 2; n++) cycle();
        chk("t5_mid_beats", 32'(acc_cyc.size() - a0), 32'd2);
        reset = 1'b1;
        flush();
        cycle();
        reset = 1'b0;
        chk("t5_busy",    32'(busy),         32'd0);
        chk("t5_out_req", 32'(out_req),      32'd0);
        chk("t5_owner",   32'(owner),        32'd0);
        chk("t5_err",     32'(oversize_err), 32'd0);
        chk("t5_pkt0",    32'(pkt_count0),   32'd0);
        g0 = grant_log.size();
        push_frame(0, 1); push_frame(1, 1);
        run_idle(20);
        if (grant_log.size() > g0) chk("t5_winner", 32'(grant_log[g0]), 32'd0);
        else flag_fail("t5_winner no grant");

        // Counter wrap: preload the src0 frame counter just below the wrap point
        force dut.r_pkt0 = 16'hFFFE;
        m_pkt[0] = 16'hFFFE;
        cycle();
        release dut.r_pkt0;
        chk("t6_preset", 32'(pkt_count0), 32'h0000FFFE);
        push_frame(0, 1); push_frame(0, 1);
        run_idle(20);
        chk("t6_wrap", 32'(pkt_count0), 32'd0);

        // Randomized traffic with request gaps, random backpressure and random err_clear
        do_reset();
        gap_pct = 30; ack_mode = 2; rand_err = 1'b1;
        for (int f = 0; f < 40; f++) push_frame(int'($urandom_range(1)), int'($urandom_range(6, 1)));
        run_idle(3000);
        gap_pct = 0; ack_mode = 0; rand_err = 1'b0; err_clear = 1'b0;
        chk("t7_left0", 32'(exp_q[0].size()), 32'd0);
        chk("t7_left1", 32'(exp_q[1].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
